// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 core constants and register-file types
package rv32_pkg;

  localparam int XLEN              = 32;
  localparam int REG_FILE_DEPTH    = 32;
  localparam int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH);

  typedef logic [REG_FILE_ADDR_LEN-1:0] rf_addr_t;
  typedef logic [XLEN-1:0]              xlen_t;

  localparam rf_addr_t REG_ZERO = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode-side read/write port bundle of the register file
interface register_file_if #(
  parameter int XLEN              = rv32_pkg::XLEN,
  parameter int REG_FILE_ADDR_LEN = rv32_pkg::REG_FILE_ADDR_LEN
) ();

  logic                         clr;
  logic                         ready;
  logic                         rd_en;
  logic [REG_FILE_ADDR_LEN-1:0] rs1;
  logic [REG_FILE_ADDR_LEN-1:0] rs2;
  logic [XLEN-1:0]              rs1_data;
  logic [XLEN-1:0]              rs2_data;
  logic                         we;
  logic [REG_FILE_ADDR_LEN-1:0] rd;
  logic [XLEN-1:0]              rd_data;

  modport master (
    output clr, rd_en, rs1, rs2, we, rd, rd_data,
    input  ready, rs1_data, rs2_data
  );

  modport slave (
    input  clr, rd_en, rs1, rs2, we, rd, rd_data,
    output ready, rs1_data, rs2_data
  );

endinterface

// File: rtl/register_file_clear_seq.sv
// rtl/register_file_clear_seq.sv - CLEAR/RUN sequencer walking a zeroing pointer over entries 1..DEPTH-1
module register_file_clear_seq #(
  parameter int REG_FILE_DEPTH    = rv32_pkg::REG_FILE_DEPTH,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  output logic                         clr_active,
  output logic [REG_FILE_ADDR_LEN-1:0] clr_addr,
  output logic                         ready
);
  import rv32_pkg::*;

  // Entry 0 is hardwired to zero on read, so the walk starts at 1.
  localparam logic [REG_FILE_ADDR_LEN-1:0] FIRST = REG_FILE_ADDR_LEN'(1);
  localparam logic [REG_FILE_ADDR_LEN-1:0] LAST  = REG_FILE_ADDR_LEN'(REG_FILE_DEPTH - 1);

  rf_state_t                    state, state_n;
  logic [REG_FILE_ADDR_LEN-1:0] ptr, ptr_n;
  logic                         ready_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= FIRST;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      CLEAR: begin
        ptr_n = ptr + 1'b1;
        if (ptr == LAST) state_n = RUN;
      end
      RUN:     ;
      default: state_n = CLEAR;
    endcase
    if (clr) begin
      state_n = CLEAR;
      ptr_n   = FIRST;
    end
    // Registered copy of the next state keeps ready free of input paths.
    ready_n = (state_n == RUN);
  end

  assign clr_active = (state == CLEAR);
  assign clr_addr   = ptr;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R1W integer register file with x0 hardwired to zero; optional REG_FILE_BYPASS_EN forwarding
module register_file #(
  parameter int XLEN              = rv32_pkg::XLEN,
  parameter int REG_FILE_DEPTH    = rv32_pkg::REG_FILE_DEPTH,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);
  import rv32_pkg::*;

  logic                         clr_active;
  logic                         ready;
  logic [REG_FILE_ADDR_LEN-1:0] clr_addr;

  logic [XLEN-1:0]              mem [REG_FILE_DEPTH];

  logic                         wr_ok;
  logic                         wr_en;
  logic [REG_FILE_ADDR_LEN-1:0] wr_addr;
  logic [XLEN-1:0]              wr_data;
  logic [XLEN-1:0]              rs1_next, rs2_next;
  logic [XLEN-1:0]              rs1_q, rs2_q;

  function automatic logic in_range(input logic [REG_FILE_ADDR_LEN-1:0] a);
    return {1'b0, a} < (REG_FILE_ADDR_LEN+1)'(REG_FILE_DEPTH);
  endfunction

  register_file_clear_seq #(
    .REG_FILE_DEPTH   (REG_FILE_DEPTH),
    .REG_FILE_ADDR_LEN(REG_FILE_ADDR_LEN)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rf.clr),
    .clr_active(clr_active),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  // A write racing a clear request loses; the clear wipes the file anyway.
  assign wr_ok = ready && rf.we && !rf.clr
              && (rf.rd != REG_FILE_ADDR_LEN'(REG_ZERO)) && in_range(rf.rd);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rf.rd;
    wr_data = rf.rd_data;
    if (clr_active) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (wr_ok) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rs1_next = '0;
    rs2_next = '0;
    if (rf.rs1 != REG_FILE_ADDR_LEN'(REG_ZERO) && in_range(rf.rs1)) rs1_next = mem[rf.rs1];
    if (rf.rs2 != REG_FILE_ADDR_LEN'(REG_ZERO) && in_range(rf.rs2)) rs2_next = mem[rf.rs2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && rf.rd == rf.rs1) rs1_next = rf.rd_data;
    if (wr_ok && rf.rd == rf.rs2) rs2_next = rf.rd_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (rf.clr || clr_active) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (rf.rd_en && ready) begin
      rs1_q <= rs1_next;
      rs2_q <= rs2_next;
    end
  end

  assign rf.ready    = ready;
  assign rf.rs1_data = rs1_q;
  assign rf.rs2_data = rs2_q;

endmodule
